vx_rop_perf_unit: RTL and testbench

Multi-port performance-counter engine for the ROP unit, the parametrised successor to the fixed four-counter ROP perf bundle. It snoops N memory request/response handshakes plus one pipeline stall indication and produces saturating read, write, accumulated-latency and stall-cycle counters. It also supports clear, freeze and a sticky overflow flag. The counters drive the master side of the ROP perf interface, and the CSR unit reads them.

---
 rtl/vx_rop_perf_unit_pkg.sv | 55 +++++
 rtl/vx_rop_perf_unit_if.sv | 24 ++
 rtl/vx_rop_perf_unit_pending.sv | 50 +++++
 rtl/vx_rop_perf_unit.sv | 130 +++++++++++++
 tb/tb_vx_rop_perf_unit.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vx_rop_perf_unit_pkg.sv
// Shared types and helpers for the ROP performance-counter engine.
// Counter bundle, saturating add with overflow, and popcount.
package vx_rop_perf_unit_pkg;

    localparam int PERF_CTR_BITS = 44;
    localparam int DEF_NUM_PORTS = 4;
    localparam int MAX_PORTS     = 16;
    localparam int MAX_CTR_BITS  = 64;

    typedef logic [MAX_CTR_BITS-1:0] wide_t;

    typedef struct packed {
        wide_t reads;
        wide_t writes;
        wide_t latency;
        wide_t stalls;
    } perf_ctrs_t;

    typedef struct packed {
        wide_t sum;
        logic  ovf;
    } sat_res_t;

    // Add b to a, clamping at 2^w-1; ovf flags a clamped result.
    function automatic sat_res_t sat_add(
        input wide_t       a,
        input wide_t       b,
        input int unsigned w
    );
        logic [MAX_CTR_BITS:0] s;
        logic [MAX_CTR_BITS:0] mx;
        sat_res_t              r;
        s  = {1'b0, a} + {1'b0, b};
        mx = ({{MAX_CTR_BITS{1'b0}}, 1'b1} << w)
           - {{MAX_CTR_BITS{1'b0}}, 1'b1};
        if (s > mx) begin
            r.sum = mx[MAX_CTR_BITS-1:0];
            r.ovf = 1'b1;
        end else begin
            r.sum = s[MAX_CTR_BITS-1:0];
            r.ovf = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) begin
            c = c + {4'b0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/vx_rop_perf_unit_if.sv
// ROP perf counter bundle; the engine drives the master side,
// the CSR unit reads the slave side.
interface vx_rop_perf_unit_if #(
    parameter int CTR_BITS = 44
);
    logic [CTR_BITS-1:0] mem_reads;
    logic [CTR_BITS-1:0] mem_writes;
    logic [CTR_BITS-1:0] mem_latency;
    logic [CTR_BITS-1:0] stall_cycles;

    modport master (
        output mem_reads,
        output mem_writes,
        output mem_latency,
        output stall_cycles
    );

    modport slave (
        input mem_reads,
        input mem_writes,
        input mem_latency,
        input stall_cycles
    );
endinterface

// File: rtl/vx_rop_perf_unit_pending.sv
// Per-port outstanding-read tracker. Saturates at both ends and
// reports an error pulse on underflow or overflow attempts.
module vx_rop_perf_unit_pending #(
    parameter int PENDING_BITS = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rd_fire_i,
    input  logic                    rsp_fire_i,
    output logic [PENDING_BITS-1:0] pending_o,
    output logic                    err_o
);

    localparam logic [PENDING_BITS-1:0] PEND_MAX = '1;
    localparam logic [PENDING_BITS-1:0] PEND_ONE = PENDING_BITS'(1);

    logic [PENDING_BITS-1:0] pend_q;
    logic [PENDING_BITS-1:0] pend_d;

    // Next pending value; a read and a response together cancel out.
    always_comb begin
        pend_d = pend_q;
        err_o  = 1'b0;
        if (rd_fire_i && !rsp_fire_i) begin
            if (pend_q == PEND_MAX) begin
                err_o = 1'b1;
            end else begin
                pend_d = pend_q + PEND_ONE;
            end
        end else if (!rd_fire_i && rsp_fire_i) begin
            if (pend_q == '0) begin
                err_o = 1'b1;
            end else begin
                pend_d = pend_q - PEND_ONE;
            end
        end
    end

    // Pending register; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pending_o = pend_q;

endmodule

// File: rtl/vx_rop_perf_unit.sv
// ROP performance-counter engine: saturating read, write, latency
// and stall counters with clear, freeze and sticky error flags.
module vx_rop_perf_unit
    import vx_rop_perf_unit_pkg::*;
#(
    parameter int NUM_PORTS    = DEF_NUM_PORTS,
    parameter int CTR_BITS     = PERF_CTR_BITS,
    parameter int PENDING_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 freeze,
    input  logic [NUM_PORTS-1:0] req_valid,
    input  logic [NUM_PORTS-1:0] req_ready,
    input  logic [NUM_PORTS-1:0] req_rw,
    input  logic [NUM_PORTS-1:0] rsp_valid,
    input  logic [NUM_PORTS-1:0] rsp_ready,
    input  logic                 pipe_stall,
    output logic [CTR_BITS-1:0]  mem_reads,
    output logic [CTR_BITS-1:0]  mem_writes,
    output logic [CTR_BITS-1:0]  mem_latency,
    output logic [CTR_BITS-1:0]  stall_cycles,
    output logic                 overflow,
    output logic                 pending_err
);

    localparam int PC_W  = $clog2(NUM_PORTS + 1);
    localparam int SUM_W = PENDING_BITS + $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0]    req_fire;
    logic [NUM_PORTS-1:0]    rd_fire;
    logic [NUM_PORTS-1:0]    wr_fire;
    logic [NUM_PORTS-1:0]    rsp_fire;
    logic [NUM_PORTS-1:0]    perr_vec;
    logic [PENDING_BITS-1:0] pend [NUM_PORTS];

    logic [PC_W-1:0]  rd_cnt;
    logic [PC_W-1:0]  wr_cnt;
    logic [SUM_W-1:0] pend_sum;
    logic             stall_ev;

    perf_ctrs_t ctr_q;
    perf_ctrs_t ctr_d;
    logic       ovf_q;
    logic       ovf_d;
    logic       perr_q;

    sat_res_t r_rd;
    sat_res_t r_wr;
    sat_res_t r_lat;
    sat_res_t r_stl;

    assign req_fire = req_valid & req_ready;
    assign rd_fire  = req_fire & ~req_rw;
    assign wr_fire  = req_fire & req_rw;
    assign rsp_fire = rsp_valid & rsp_ready;
    assign stall_ev = pipe_stall | (|(req_valid & ~req_ready));

    assign rd_cnt = PC_W'(popcount16(16'(rd_fire)));
    assign wr_cnt = PC_W'(popcount16(16'(wr_fire)));

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        vx_rop_perf_unit_pending #(
            .PENDING_BITS (PENDING_BITS)
        ) u_pend (
            .clk        (clk),
            .reset      (reset),
            .rd_fire_i  (rd_fire[i]),
            .rsp_fire_i (rsp_fire[i]),
            .pending_o  (pend[i]),
            .err_o      (perr_vec[i])
        );
    end

    // Total outstanding reads, taken before this cycle's update.
    always_comb begin
        pend_sum = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            pend_sum = pend_sum + SUM_W'(pend[i]);
        end
    end

    // Saturating next-state for all four counters.
    always_comb begin
        r_rd  = sat_add(ctr_q.reads, wide_t'(rd_cnt), CTR_BITS);
        r_wr  = sat_add(ctr_q.writes, wide_t'(wr_cnt), CTR_BITS);
        r_lat = sat_add(ctr_q.latency, wide_t'(pend_sum), CTR_BITS);
        r_stl = sat_add(ctr_q.stalls, wide_t'(stall_ev), CTR_BITS);
        ctr_d.reads   = r_rd.sum;
        ctr_d.writes  = r_wr.sum;
        ctr_d.latency = r_lat.sum;
        ctr_d.stalls  = r_stl.sum;
        ovf_d = r_rd.ovf | r_wr.ovf | r_lat.ovf | r_stl.ovf;
    end

    // Counter and flag state: reset > clear > freeze > count.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctr_q  <= '0;
            ovf_q  <= 1'b0;
            perr_q <= 1'b0;
        end else if (clear) begin
            ctr_q  <= '0;
            ovf_q  <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            if (!freeze) begin
                ctr_q <= ctr_d;
                ovf_q <= ovf_q | ovf_d;
            end
            perr_q <= perr_q | (|perr_vec);
        end
    end

    vx_rop_perf_unit_if #(.CTR_BITS(CTR_BITS)) perf_if ();

    assign perf_if.mem_reads    = ctr_q.reads[CTR_BITS-1:0];
    assign perf_if.mem_writes   = ctr_q.writes[CTR_BITS-1:0];
    assign perf_if.mem_latency  = ctr_q.latency[CTR_BITS-1:0];
    assign perf_if.stall_cycles = ctr_q.stalls[CTR_BITS-1:0];

    assign mem_reads    = perf_if.mem_reads;
    assign mem_writes   = perf_if.mem_writes;
    assign mem_latency  = perf_if.mem_latency;
    assign stall_cycles = perf_if.stall_cycles;
    assign overflow     = ovf_q;
    assign pending_err  = perr_q;

endmodule

// File: tb/tb_vx_rop_perf_unit.sv
// Directed bench for vx_rop_perf_unit: a wide-counter instance
// and a 4-bit-counter / 2-bit-pending instance share stimulus.
module tb_vx_rop_perf_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic       freeze;
    logic [3:0] req_valid;
    logic [3:0] req_ready;
    logic [3:0] req_rw;
    logic [3:0] rsp_valid;
    logic [3:0] rsp_ready;
    logic       pipe_stall;

    logic [15:0] a_reads, a_writes, a_lat, a_stl;
    logic        a_ovf, a_perr;
    logic [3:0]  b_reads, b_writes, b_lat, b_stl;
    logic        b_ovf, b_perr;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vx_rop_perf_unit #(
        .NUM_PORTS    (4),
        .CTR_BITS     (16),
        .PENDING_BITS (8)
    ) u_a (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .freeze       (freeze),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_rw       (req_rw),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .pipe_stall   (pipe_stall),
        .mem_reads    (a_reads),
        .mem_writes   (a_writes),
        .mem_latency  (a_lat),
        .stall_cycles (a_stl),
        .overflow     (a_ovf),
        .pending_err  (a_perr)
    );

    vx_rop_perf_unit #(
        .NUM_PORTS    (4),
        .CTR_BITS     (4),
        .PENDING_BITS (2)
    ) u_b (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .freeze       (freeze),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_rw       (req_rw),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .pipe_stall   (pipe_stall),
        .mem_reads    (b_reads),
        .mem_writes   (b_writes),
        .mem_latency  (b_lat),
        .stall_cycles (b_stl),
        .overflow     (b_ovf),
        .pending_err  (b_perr)
    );

    typedef struct {
        logic [3:0]  rv, rr, rw, sv, sr;
        logic        st, clr, frz;
        int unsigned rd, wr, lat, stl;
        logic        ov, pe;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mk(
        input logic [3:0] rv, rr, rw, sv, sr,
        input logic st, clr, frz,
        input int unsigned rd, wr, lat, stl,
        input logic ov, pe
    );
        vec_t v;
        v.rv = rv; v.rr = rr; v.rw = rw; v.sv = sv; v.sr = sr;
        v.st = st; v.clr = clr; v.frz = frz;
        v.rd = rd; v.wr = wr; v.lat = lat; v.stl = stl;
        v.ov = ov; v.pe = pe;
        return v;
    endfunction

    task automatic chk(
        input string           nm,
        input longint unsigned act,
        input longint unsigned exp
    );
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_in(
        input logic [3:0] rv, rr, rw, sv, sr,
        input logic st, clr, frz
    );
        req_valid  = rv;
        req_ready  = rr;
        req_rw     = rw;
        rsp_valid  = sv;
        rsp_ready  = sr;
        pipe_stall = st;
        clear      = clr;
        freeze     = frz;
    endtask

    task automatic idle();
        set_in(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        // rv rr rw sv sr st clr frz | rd wr lat stl ov pe
        tbl[0]  = mk(4'h0,4'h0,4'h0,4'h0,4'h0,0,0,0, 0,0,0,0,0,0);
        tbl[1]  = mk(4'h7,4'h7,4'h2,4'h0,4'h0,0,0,0, 2,1,0,0,0,0);
        tbl[2]  = mk(4'h0,4'h0,4'h0,4'h0,4'h0,0,0,0, 2,1,2,0,0,0);
        tbl[3]  = mk(4'h0,4'h0,4'h0,4'h5,4'h5,0,0,0, 2,1,4,0,0,0);
        tbl[4]  = mk(4'h0,4'h0,4'h0,4'h0,4'h0,0,0,0, 2,1,4,0,0,0);
        tbl[5]  = mk(4'h8,4'h0,4'h0,4'h0,4'h0,0,0,0, 2,1,4,1,0,0);
        tbl[6]  = mk(4'h8,4'h0,4'h0,4'h0,4'h0,1,0,0, 2,1,4,2,0,0);
        tbl[7]  = mk(4'h0,4'h0,4'h0,4'h0,4'h0,1,0,0, 2,1,4,3,0,0);
        tbl[8]  = mk(4'h1,4'h0,4'h0,4'h1,4'h0,0,0,0, 2,1,4,4,0,0);
        tbl[9]  = mk(4'hF,4'hF,4'h0,4'h0,4'h0,0,1,0, 0,0,0,0,0,0);
        tbl[10] = mk(4'h0,4'h0,4'h0,4'h0,4'h0,0,0,0, 0,0,4,0,0,0);
        tbl[11] = mk(4'h0,4'h0,4'h0,4'hF,4'hF,0,0,0, 0,0,8,0,0,0);
        tbl[12] = mk(4'hF,4'hF,4'h0,4'h0,4'h0,0,0,1, 0,0,8,0,0,0);
        tbl[13] = mk(4'h0,4'h0,4'h0,4'h0,4'h0,0,0,0, 0,0,12,0,0,0);
        tbl[14] = mk(4'h0,4'h0,4'h0,4'hF,4'hF,0,0,0, 0,0,16,0,0,0);
        tbl[15] = mk(4'h0,4'h0,4'h0,4'h2,4'h2,0,0,0, 0,0,16,0,0,1);
        tbl[16] = mk(4'h0,4'h0,4'h0,4'h0,4'h0,0,1,0, 0,0,0,0,0,0);

        step();
        step();
        reset = 1'b0;
        chk("rst.a_reads", a_reads, 0);
        chk("rst.a_writes", a_writes, 0);
        chk("rst.a_lat", a_lat, 0);
        chk("rst.a_stl", a_stl, 0);
        chk("rst.a_ovf", a_ovf, 0);
        chk("rst.a_perr", a_perr, 0);
        chk("rst.b_reads", b_reads, 0);

        for (int i = 0; i < 17; i++) begin
            set_in(tbl[i].rv, tbl[i].rr, tbl[i].rw, tbl[i].sv,
                   tbl[i].sr, tbl[i].st, tbl[i].clr, tbl[i].frz);
            step();
            chk($sformatf("v%0d.reads", i), a_reads, tbl[i].rd);
            chk($sformatf("v%0d.writes", i), a_writes, tbl[i].wr);
            chk($sformatf("v%0d.lat", i), a_lat, tbl[i].lat);
            chk($sformatf("v%0d.stl", i), a_stl, tbl[i].stl);
            chk($sformatf("v%0d.ovf", i), a_ovf, tbl[i].ov);
            chk($sformatf("v%0d.perr", i), a_perr, tbl[i].pe);
        end

        // One read on port 0, response five cycles later.
        do_reset();
        set_in(4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 0, 0, 0);
        step();
        idle();
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k == 3) chk("lat.mid", a_lat, 3);
        end
        set_in(4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 0, 0, 0);
        step();
        chk("lat.rsp", a_lat, 5);
        idle();
        step();
        chk("lat.after", a_lat, 5);
        chk("lat.perr", a_perr, 0);

        // Read and response together keep pending at 1.
        do_reset();
        set_in(4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 0, 0, 0);
        step();
        set_in(4'h1, 4'h1, 4'h0, 4'h1, 4'h1, 0, 0, 0);
        step();
        idle();
        step();
        step();
        chk("same.lat", a_lat, 3);
        chk("same.reads", a_reads, 2);
        chk("same.perr", a_perr, 0);

        // Port 3 blocked 7 cycles, pipe_stall on 3 of them.
        do_reset();
        for (int k = 0; k < 7; k++) begin
            set_in(4'h8, 4'h0, 4'h0, 4'h0, 4'h0, k < 3, 0, 0);
            step();
        end
        chk("stall.cnt", a_stl, 7);
        chk("stall.reads", a_reads, 0);

        // 20 reads: narrow counter clamps at 15, then clear.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            set_in(4'hF, 4'hF, 4'h0, 4'hF, 4'hF, 0, 0, 0);
            step();
        end
        chk("sat.b_reads", b_reads, 15);
        chk("sat.b_ovf", b_ovf, 1);
        chk("sat.a_reads", a_reads, 20);
        chk("sat.a_ovf", a_ovf, 0);
        chk("sat.b_perr", b_perr, 0);
        set_in(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 1, 0);
        step();
        chk("clr.b_reads", b_reads, 0);
        chk("clr.b_ovf", b_ovf, 0);
        chk("clr.a_reads", a_reads, 0);

        // Narrow pending tracker tops out at 3.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_in(4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 0, 0, 0);
            step();
            if (k == 2) chk("pmax.b_perr0", b_perr, 0);
        end
        chk("pmax.b_perr1", b_perr, 1);
        chk("pmax.a_perr", a_perr, 0);
        chk("pmax.b_lat", b_lat, 6);
        idle();
        for (int k = 0; k < 3; k++) step();
        chk("lsat.b_lat15", b_lat, 15);
        chk("lsat.b_ovf0", b_ovf, 0);
        step();
        chk("lsat.b_lat", b_lat, 15);
        chk("lsat.b_ovf1", b_ovf, 1);
        chk("lsat.a_lat", a_lat, 22);

        // Freeze drops events but pending keeps tracking.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            set_in(4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 0, 0, 1);
            step();
        end
        chk("frz.reads", a_reads, 0);
        chk("frz.lat", a_lat, 0);
        idle();
        step();
        chk("frz.lat1", a_lat, 10);
        step();
        chk("frz.lat2", a_lat, 20);
        chk("frz.reads2", a_reads, 0);

        // Reset mid-burst discards in-flight reads.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            set_in(4'hF, 4'hF, 4'h5, 4'h0, 4'h0, 0, 0, 0);
            step();
        end
        chk("burst.reads", a_reads, 4);
        chk("burst.writes", a_writes, 4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mrst.reads", a_reads, 0);
        chk("mrst.writes", a_writes, 0);
        chk("mrst.lat", a_lat, 0);
        set_in(4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 0, 0, 0);
        step();
        chk("mrst.perr", a_perr, 1);
        chk("mrst.lat2", a_lat, 0);
        idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
